// File: rtl/cache_sram.sv
// Set-associative storage array behind the dcache SRAM port: one full-set read or
// write at a time, completed a fixed LAT cycles after the request is sampled.
module cache_sram #(
    parameter int SETS  = 16,
    parameter int WAYS  = 2,
    parameter int TAG_W = 26,
    parameter int WORDS = 2,
    parameter int LAT   = 4,
    localparam int IDX_W  = $clog2(SETS),
    localparam int WAY_W  = 2 + TAG_W + 32*WORDS,
    localparam int LINE_W = WAYS*WAY_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              sramREN,
    input  logic              sramWEN,
    input  logic [31:0]       sramaddr,
    input  logic [LINE_W-1:0] ramstore,
    output logic [1:0]        sramstate,
    output logic [LINE_W-1:0] cacheline
);
    localparam int TD_W = TAG_W + 32*WORDS;

    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] store_q, store_d;
    logic [LINE_W-1:0] line_q, line_d;

    logic [WAYS-1:0]   v_q  [SETS];
    logic [WAYS-1:0]   d_q  [SETS];
    logic [TD_W-1:0]   td_q [SETS][WAYS];

    logic              commit;
    logic              acc_wr;
    logic [IDX_W-1:0]  acc_idx;
    logic [LINE_W-1:0] acc_store;
    logic [LINE_W-1:0] rd_line;
    logic              unused_addr;

    assign unused_addr = ^sramaddr[31:IDX_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        store_d   = store_q;
        commit    = 1'b0;
        acc_wr    = wr_q;
        acc_idx   = idx_q;
        acc_store = store_q;
        case (state_q)
            FREE: begin
                if (sramWEN | sramREN) begin
                    wr_d    = sramWEN;
                    idx_d   = sramaddr[IDX_W-1:0];
                    store_d = ramstore;
                    // With LAT==1 the access completes on the sampling edge, so it
                    // must use the live inputs rather than the latched copy.
                    if (LAT == 1) begin
                        state_d   = ACCESS;
                        commit    = 1'b1;
                        acc_wr    = sramWEN;
                        acc_idx   = sramaddr[IDX_W-1:0];
                        acc_store = ramstore;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(LAT - 1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACCESS;
                    commit  = 1'b1;
                end
            end
            ACCESS:  state_d = FREE;
            default: state_d = FREE;
        endcase
    end

    always_comb begin
        rd_line = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            rd_line[w*WAY_W +: WAY_W] = {v_q[acc_idx][w], d_q[acc_idx][w], td_q[acc_idx][w]};
        end
        line_d = line_q;
        if (commit) begin
            line_d = acc_wr ? acc_store : rd_line;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= FREE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            store_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            store_q <= store_d;
            line_q  <= line_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                v_q[s] <= '0;
                d_q[s] <= '0;
            end
        end else if (commit && acc_wr) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                v_q[acc_idx][w] <= acc_store[w*WAY_W + WAY_W - 1];
                d_q[acc_idx][w] <= acc_store[w*WAY_W + WAY_W - 2];
            end
        end
    end

    // Tag/data carry no reset; a write abandoned by reset must not land here either.
    always_ff @(posedge CLK) begin
        if (nRST && commit && acc_wr) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                td_q[acc_idx][w] <= acc_store[w*WAY_W +: TD_W];
            end
        end
    end

    assign sramstate = state_q;
    assign cacheline = line_q;
endmodule

// File: tb/tb_cache_sram.sv
// Self-checking bench for cache_sram: table vectors, hand-written corner sequences
// and random traffic checked against an array-of-lines reference model.
module tb_cache_sram;
    localparam int SETS   = 16;
    localparam int WAYS   = 2;
    localparam int TAG_W  = 26;
    localparam int WORDS  = 2;
    localparam int LAT    = 4;
    localparam int WAY_W  = 2 + TAG_W + 32*WORDS;
    localparam int LINE_W = WAYS*WAY_W;

    typedef logic [LINE_W-1:0] line_t;

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        line_t       st;
        bit          mutate;
        line_t       exp;
        line_t       msk;
    } vec_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        ren, wen, ren1, wen1;
    logic [31:0] addr, addr1;
    line_t       store, store1;
    logic [1:0]  state, state1;
    line_t       line, line1;

    int tests = 0;
    int fails = 0;

    line_t model [SETS];
    bit    written [SETS];
    line_t last_exp, last_msk;
    line_t vdm, full;
    line_t l1 [3];
    vec_t  vecs [9];

    cache_sram #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .WORDS(WORDS), .LAT(LAT)) dut (
        .CLK(clk), .nRST(nrst), .sramREN(ren), .sramWEN(wen), .sramaddr(addr),
        .ramstore(store), .sramstate(state), .cacheline(line)
    );

    cache_sram #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .WORDS(WORDS), .LAT(1)) dut1 (
        .CLK(clk), .nRST(nrst), .sramREN(ren1), .sramWEN(wen1), .sramaddr(addr1),
        .ramstore(store1), .sramstate(state1), .cacheline(line1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [WAY_W-1:0] mk_way(input logic v, input logic d,
                                                input logic [TAG_W-1:0] tag,
                                                input logic [63:0] data);
        return {v, d, tag, data};
    endfunction

    function automatic line_t rand_line();
        logic [191:0] r;
        for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
        return r[LINE_W-1:0];
    endfunction

    task automatic check(input string nm, input line_t act, input line_t exp, input line_t msk);
        tests++;
        if ((act & msk) !== (exp & msk)) begin
            fails++;
            $display("FAIL %s: got %h, required %h (mask %h)", nm, act, exp, msk);
        end
    endtask

    task automatic check_st(input string nm, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got state %0d, required %0d", nm, act, exp);
        end
    endtask

    function automatic line_t model_exp(input int idx);
        return model[idx];
    endfunction

    // One full access on the LAT=4 instance; checks every cycle's state and the result.
    task automatic run_access(input logic w, input logic r, input logic [31:0] a, input line_t st,
                              input bit mutate, input line_t exp, input line_t msk, input string nm);
        @(negedge clk);
        wen = w; ren = r; addr = a; store = st;
        @(posedge clk); #1;
        if (mutate) begin
            addr = 32'd9; ren = 1'b0; wen = 1'b1; store = ~st;
        end else begin
            wen = 1'b0; ren = 1'b0;
        end
        for (int k = 1; k <= LAT + 1; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k < LAT) begin
                check_st({nm, " busy"}, state, 2'd1);
                check({nm, " hold"}, line, last_exp, last_msk);
            end else if (k == LAT) begin
                check_st({nm, " access"}, state, 2'd2);
                check({nm, " line"}, line, exp, msk);
                wen = 1'b0; ren = 1'b0;
            end else begin
                check_st({nm, " free"}, state, 2'd0);
            end
        end
        last_exp = exp;
        last_msk = msk;
        if (w) begin
            model[a[3:0]]   = st;
            written[a[3:0]] = 1'b1;
        end
    endtask

    initial begin
        line_t s5, s7, s4, s2, st, ex, mk;
        logic  w, r;
        int    idx;

        vdm = '0;
        for (int i = 0; i < WAYS; i++) begin
            vdm[i*WAY_W + WAY_W - 1] = 1'b1;
            vdm[i*WAY_W + WAY_W - 2] = 1'b1;
        end
        full = '1;
        for (int i = 0; i < SETS; i++) begin
            model[i] = '0;
            written[i] = 1'b0;
        end
        s5 = {mk_way(1'b0, 1'b1, 26'h155, 64'h1111_2222_3333_4444),
              mk_way(1'b1, 1'b1, 26'h2A, 64'hDEADBEEF_01234567)};
        s7 = {mk_way(1'b1, 1'b0, 26'h3FF_FFFF, 64'hCAFEF00D_55AA55AA),
              mk_way(1'b1, 1'b1, 26'h0123456, 64'h0F0F0F0F_F0F0F0F0)};
        s4 = {mk_way(1'b1, 1'b0, 26'h0ABCDEF, 64'h89ABCDEF_76543210),
              mk_way(1'b1, 1'b0, 26'h1000001, 64'hA5A5A5A5_5A5A5A5A)};
        s2 = {mk_way(1'b1, 1'b1, 26'h0000777, 64'h12345678_9ABCDEF0),
              mk_way(1'b1, 1'b1, 26'h0000888, 64'hFFFF0000_0000FFFF)};

        vecs[0] = '{w:1'b0, r:1'b1, a:32'd3,         st:'0, mutate:1'b0, exp:'0, msk:vdm};
        vecs[1] = '{w:1'b1, r:1'b0, a:32'd5,         st:s5, mutate:1'b0, exp:s5, msk:full};
        vecs[2] = '{w:1'b0, r:1'b1, a:32'd5,         st:'0, mutate:1'b0, exp:s5, msk:full};
        vecs[3] = '{w:1'b1, r:1'b1, a:32'd7,         st:s7, mutate:1'b0, exp:s7, msk:full};
        vecs[4] = '{w:1'b0, r:1'b1, a:32'd7,         st:'0, mutate:1'b0, exp:s7, msk:full};
        vecs[5] = '{w:1'b0, r:1'b1, a:32'd5,         st:'0, mutate:1'b1, exp:s5, msk:full};
        vecs[6] = '{w:1'b1, r:1'b0, a:32'hFFFF_FFF4, st:s4, mutate:1'b1, exp:s4, msk:full};
        vecs[7] = '{w:1'b0, r:1'b1, a:32'd4,         st:'0, mutate:1'b0, exp:s4, msk:full};
        vecs[8] = '{w:1'b0, r:1'b1, a:32'd9,         st:'0, mutate:1'b0, exp:'0, msk:vdm};

        nrst = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; store = '0;
        ren1 = 1'b0; wen1 = 1'b0; addr1 = '0; store1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_st("reset state", state, 2'd0);
        check("reset line", line, '0, full);
        check_st("reset state lat1", state1, 2'd0);
        check("reset line lat1", line1, '0, full);
        last_exp = '0;
        last_msk = full;
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_access(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].st, vecs[i].mutate,
                       vecs[i].exp, vecs[i].msk, $sformatf("vec%0d", i));
        end

        // Reset lands in the middle of a write to set 2.
        @(negedge clk);
        wen = 1'b1; addr = 32'd2; store = s2;
        @(posedge clk); #1;
        wen = 1'b0;
        @(posedge clk); #1;
        check_st("rst-mid busy", state, 2'd1);
        @(negedge clk);
        nrst = 1'b0;
        @(posedge clk); #1;
        check_st("rst-mid state", state, 2'd0);
        check("rst-mid line", line, '0, full);
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < SETS; i++) model[i] = model[i] & ~vdm;
        last_exp = '0;
        last_msk = full;
        run_access(1'b0, 1'b1, 32'd2, '0, 1'b0, '0, vdm, "rst-mid read2");
        run_access(1'b0, 1'b1, 32'd5, '0, 1'b0, model_exp(5), full, "rst-mid read5");

        for (int n = 0; n < 40; n++) begin
            w   = ($urandom_range(0, 2) == 0);
            r   = w ? 1'($urandom) : 1'b1;
            idx = $urandom_range(0, SETS - 1);
            st  = rand_line();
            if (w) begin
                ex = st; mk = full;
            end else begin
                ex = model_exp(idx); mk = written[idx] ? full : vdm;
            end
            run_access(w, r, {$urandom_range(0, 255), 20'h0, 4'(idx)}, st, 1'b0, ex, mk,
                       $sformatf("rnd%0d", n));
        end

        // LAT=1 instance: fill three sets, then hold REN high continuously.
        for (int i = 0; i < 3; i++) begin
            l1[i] = rand_line();
            @(negedge clk);
            wen1 = 1'b1; addr1 = i; store1 = l1[i];
            @(posedge clk); #1;
            check_st("lat1 wr access", state1, 2'd2);
            check("lat1 wr line", line1, l1[i], full);
            wen1 = 1'b0;
            @(posedge clk); #1;
            check_st("lat1 wr free", state1, 2'd0);
        end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            ren1 = 1'b1; addr1 = j % 3;
            @(posedge clk); #1;
            check_st("lat1 held access", state1, 2'd2);
            check("lat1 held line", line1, l1[j % 3], full);
            @(negedge clk);
            addr1 = 32'd3;
            @(posedge clk); #1;
            check_st("lat1 held free", state1, 2'd0);
            check("lat1 held stable", line1, l1[j % 3], full);
        end
        ren1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
